// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction-fetch
// port (read-only) and the data-memory port. Data requests win arbitration
// unless fetch has already waited through MAX_DM_STREAK consecutive data
// grants. A bus cycle that is not acked within TIMEOUT cycles is aborted. The
// abort is reported as an ack with err_o=1 and zero read data.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req_i/if_addr_i        fetch request and address (held until if_ack_o)
//   if_ack_o/if_rdata_o       one-cycle fetch completion and instruction
//   dm_req_i/dm_we_i/...      data request, write enable, address, byte enables, store data
//   dm_ack_o/dm_rdata_o       one-cycle data completion and load data
//   err_o                     qualifies an ack whose transaction timed out
//   bus_*_o                   registered external bus request signals
//   bus_ack_i/bus_rdata_i     bus completion and same-cycle read data
//   stallreq_if_o/_mem_o      pipeline stall requests (combinational)
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 3,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy, StDone} state_e;

    localparam logic [7:0] MaxStreak   = 8'(MAX_DM_STREAK);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        streak_q, streak_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              fetch_starved;

    // Fetch has waited long enough: a contested arbitration must go to IF.
    assign fetch_starved = if_req_i && (streak_q == MaxStreak);

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (dm_req_i && !fetch_starved) begin
                    state_d     = StDmBusy;
                    owner_dm_d  = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we_i;
                    bus_addr_d  = dm_addr_i;
                    bus_sel_d   = dm_sel_i;
                    bus_wdata_d = dm_wdata_i;
                    cnt_d       = 8'd0;
                    if (!if_req_i) begin
                        streak_d = 8'd0;
                    end else if (streak_q != MaxStreak) begin
                        streak_d = streak_q + 8'd1;
                    end
                end else if (if_req_i) begin
                    state_d     = StIfBusy;
                    owner_dm_d  = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr_i;
                    bus_sel_d   = 4'b1111;
                    bus_wdata_d = '0;
                    cnt_d       = 8'd0;
                    streak_d    = 8'd0;
                end
            end
            StIfBusy, StDmBusy: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    state_d   = StDone;
                    rdata_d   = bus_we_q ? '0 : bus_rdata_i;
                    bus_req_d = 1'b0;
                    err_d     = 1'b0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = StDone;
                    rdata_d   = '0;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_dm_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            streak_q    <= 8'd0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
        end
    end

    assign if_ack_o       = (state_q == StDone) && !owner_dm_q;
    assign dm_ack_o       = (state_q == StDone) && owner_dm_q;
    assign if_rdata_o     = if_ack_o ? rdata_q : '0;
    assign dm_rdata_o     = dm_ack_o ? rdata_q : '0;
    assign err_o          = (state_q == StDone) && err_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign stallreq_if_o  = if_req_i && !if_ack_o;
    assign stallreq_mem_o = dm_req_i && !dm_ack_o;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the instruction-fetch port (IF, read-only) and the data-memory port (MEM stage).
- Grants the bus to one master per transaction, with data priority and a bounded starvation guard for fetch.
- Returns read data and ack to the granted master, and aborts any transaction that times out.
- Raises per-stage stall requests that the pipeline control block uses to freeze PC, IF/ID and the EX/MEM/WB registers.

Parameters:
- ADDR_W, 32, address width (matches InstAddrBus/RegBus).
- DATA_W, 32, data width.
- MAX_DM_STREAK, 3, consecutive data grants allowed while IF waits; the next arbitration must go to IF.
- TIMEOUT, 16, bus cycles in a BUSY state without ack before abort (valid range 2..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ack_o  out  1  one-cycle completion pulse to IF.
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ack_o=1.
- dm_req_i  in  1  data request; held until dm_ack_o.
- dm_we_i  in  1  1 = write.
- dm_addr_i  in  ADDR_W  data address.
- dm_sel_i  in  4  byte enables.
- dm_wdata_i  in  DATA_W  store data.
- dm_ack_o  out  1  one-cycle completion pulse to MEM.
- dm_rdata_o  out  DATA_W  load data; valid while dm_ack_o=1.
- err_o  out  1  qualifies the ack of an aborted (timed-out) transaction.
- bus_req_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  bus address.
- bus_sel_o  out  4  bus byte enables.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_ack_i  in  1  bus completion; bus_rdata_i is valid in the same cycle.
- bus_rdata_i  in  DATA_W  bus read data.
- stallreq_if_o  out  1  = if_req_i & ~if_ack_o (combinational).
- stallreq_mem_o  out  1  = dm_req_i & ~dm_ack_o (combinational).

Behaviour:
- FSM states: IDLE, IF_BUSY, DM_BUSY, DONE.
- Reset:
  - state=IDLE; all registered outputs 0; dm_streak=0; timeout counter=0.
  - Reset mid-transaction returns the block to IDLE next cycle with bus_req_o=0. Any later bus_ack_i for the abandoned cycle is ignored.
- IDLE arbitration (one edge):
  - dm_req_i only -> DM_BUSY.
  - if_req_i only -> IF_BUSY.
  - Both requesting -> DM_BUSY, unless dm_streak==MAX_DM_STREAK, in which case IF_BUSY.
  - On the granting edge, address, we, sel and wdata are latched into the bus_* registers and bus_req_o=1. IF grants drive bus_we_o=0 and bus_sel_o=4'b1111.
- dm_streak:
  - DM grant with if_req_i=1: increment (saturate at MAX_DM_STREAK).
  - DM grant with if_req_i=0: clear to 0.
  - IF grant: clear to 0.
- BUSY states:
  - Bus outputs are held stable; master inputs are not re-sampled.
  - bus_ack_i=1 -> DONE: rdata register <= bus_rdata_i (0 for writes), bus_req_o<=0, err<=0.
  - Counter reaches TIMEOUT-1 with no ack -> DONE with err=1, rdata=0, bus_req_o<=0.
  - Ack and timeout in the same cycle: ack wins, err=0.
- DONE (exactly one cycle):
  - Owner's ack_o=1, matching rdata_o valid; err_o valid only alongside an ack.
  - Next state is always IDLE. The master must update or drop its req by the IDLE cycle.
- Ack hygiene: bus_ack_i in IDLE or DONE is ignored. Non-owner ack and rdata outputs stay 0.
- Timing: minimum access = 3 cycles (grant, bus cycle acked same cycle, DONE), then 1 IDLE cycle before the next grant.
- Counter width: 8 bits, cleared on every grant.

Test Plan:
- IF-only read: if_req_i=1, addr 0x0000_0010, bus acks first BUSY cycle with 0x3401_0020 -> bus_req_o high cycle 1, if_ack_o=1 with if_rdata_o=0x3401_0020 in cycle 2, err_o=0, stallreq_if_o drops in cycle 2.
- Simultaneous requests: if_req_i=dm_req_i=1 (dm write 0x8, sel 4'b0011, data 0xDEAD_BEEF) -> DM granted first, bus_we_o=1, bus_sel_o=4'b0011; IF granted on the next IDLE.
- Starvation guard: if_req_i held high, dm_req_i re-asserted every IDLE -> exactly 3 DM grants, then 1 IF grant, then DM resumes.
- Timeout: DM read, bus never acks -> dm_ack_o=1, err_o=1, dm_rdata_o=0 in the cycle after the 16th BUSY cycle; bus_req_o low from DONE.
- Ack on timeout cycle: bus_ack_i=1 in the 16th BUSY cycle with data 0x1234_5678 -> err_o=0, rdata 0x1234_5678.
- Reset mid-BUSY: rst=1 for one cycle during DM_BUSY -> next cycle IDLE, bus_req_o=0; late bus_ack_i produces no dm_ack_o.
